// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared register-file constants and writeback entry type
package rv_pkg;

  localparam int REG_AW = 5;
  localparam int XLEN   = 32;
  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

  // One buffered register-file write: destination plus data
  typedef struct packed {
    logic [REG_AW-1:0] waddr;
    logic [XLEN-1:0]   wd;
  } wb_entry_t;

endpackage

// File: rtl/rf_wb_fifo.sv
// rtl/rf_wb_fifo.sv - small synchronous FIFO holding MDU writeback entries
module rf_wb_fifo
  import rv_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  wb_entry_t        push_data,
  input  logic             pop,
  output wb_entry_t        head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Storage array: written on an accepted push, never reset (contents qualified by count)
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - shares the register-file write port between pipeline and MDU
module rf_wb_arbiter
  import rv_pkg::*;
#(
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 4,
  parameter int AGE_W    = $clog2(MAX_WAIT + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pipe_we,
  input  logic [REG_AW-1:0] pipe_waddr,
  input  logic [XLEN-1:0]   pipe_wd,
  output logic              pipe_stall,
  input  logic              mdu_valid,
  input  logic [REG_AW-1:0] mdu_waddr,
  input  logic [XLEN-1:0]   mdu_wd,
  output logic              mdu_ready,
  input  logic              issue_valid,
  input  logic [REG_AW-1:0] issue_rd,
  input  logic [REG_AW-1:0] rs1_addr,
  input  logic [REG_AW-1:0] rs2_addr,
  output logic              rs1_busy,
  output logic              rs2_busy,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [XLEN-1:0]   rf_wd
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int NREGS = 1 << REG_AW;
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(MAX_WAIT);

  wb_entry_t        push_data;
  wb_entry_t        head;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full;
  logic             fifo_empty;
  logic [AGE_W-1:0] age;
  logic             force_mdu;
  logic             grant_mdu;
  logic             grant_pipe;
  logic [NREGS-1:0] sb;
  logic [NREGS-1:0] sb_next;

  assign push_data = '{waddr: mdu_waddr, wd: mdu_wd};
  assign mdu_ready = ~fifo_full;

  rf_wb_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (mdu_valid),
    .push_data (push_data),
    .pop       (grant_mdu),
    .head      (head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Slot arbitration: pipeline wins unless the MDU head has waited too long or the pipe is idle
  always_comb begin
    force_mdu  = ~fifo_empty & (age >= AGE_MAX);
    grant_mdu  = ~fifo_empty & (~pipe_we | force_mdu);
    grant_pipe = pipe_we & ~grant_mdu;
    pipe_stall = pipe_we & grant_mdu;
    rf_we      = 1'b0;
    rf_waddr   = REG_ZERO;
    rf_wd      = '0;
    if (grant_mdu) begin
      rf_we    = (head.waddr != REG_ZERO);
      rf_waddr = head.waddr;
      rf_wd    = head.wd;
    end else if (grant_pipe) begin
      rf_we    = (pipe_waddr != REG_ZERO);
      rf_waddr = pipe_waddr;
      rf_wd    = pipe_wd;
    end
  end

  // Head age: counts cycles the head sat unpopped, saturating at the force threshold
  always_ff @(posedge clk) begin
    if (rst) begin
      age <= '0;
    end else if ((fifo_count == '0) || grant_mdu) begin
      age <= '0;
    end else if (age < AGE_MAX) begin
      age <= age + AGE_W'(1);
    end
  end

  // Scoreboard next state: retire on MDU grant, then a new issue to the same register re-arms it
  always_comb begin
    sb_next = sb;
    if (grant_mdu) begin
      sb_next[head.waddr] = 1'b0;
    end
    if (issue_valid && (issue_rd != REG_ZERO)) begin
      sb_next[issue_rd] = 1'b1;
    end
    sb_next[0] = 1'b0;
  end

  // Scoreboard register
  always_ff @(posedge clk) begin
    if (rst) begin
      sb <= '0;
    end else begin
      sb <= sb_next;
    end
  end

  assign rs1_busy = sb[rs1_addr];
  assign rs2_busy = sb[rs2_addr];

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb/tb_rf_wb_arbiter.sv - scoreboard bench for rf_wb_arbiter with a queue-based reference model
module tb_rf_wb_arbiter;
  import rv_pkg::*;

  localparam int DEPTH    = 2;
  localparam int MAX_WAIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_we;
  logic [4:0]  pipe_waddr;
  logic [31:0] pipe_wd;
  logic        pipe_stall;
  logic        mdu_valid;
  logic [4:0]  mdu_waddr;
  logic [31:0] mdu_wd;
  logic        mdu_ready;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic        rs1_busy;
  logic        rs2_busy;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wd;

  always #5 clk = ~clk;

  rf_wb_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .pipe_we(pipe_we), .pipe_waddr(pipe_waddr), .pipe_wd(pipe_wd), .pipe_stall(pipe_stall),
    .mdu_valid(mdu_valid), .mdu_waddr(mdu_waddr), .mdu_wd(mdu_wd), .mdu_ready(mdu_ready),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wd(rf_wd)
  );

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  typedef struct {
    bit          we;
    logic [4:0]  a;
    logic [31:0] d;
    bit          stall;
    bit          ready;
    bit          b1;
    bit          b2;
  } exp_t;

  ent_t mq[$];
  exp_t expq[$];
  int   head_wait;
  bit   busy_m[32];
  bit   model_on = 0;
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  // Reference model: computes this cycle's expected outputs, then advances to the next edge
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (model_on) begin
        exp_t e;
        bit hv, frc, gm, gp, push;
        hv  = (mq.size() > 0);
        frc = hv && (head_wait >= MAX_WAIT);
        gm  = hv && (!pipe_we || frc);
        gp  = pipe_we && !gm;
        e.stall = pipe_we && gm;
        e.ready = (mq.size() < DEPTH);
        e.we = 0; e.a = 5'd0; e.d = 32'd0;
        if (gm) begin
          e.we = (mq[0].a != 5'd0); e.a = mq[0].a; e.d = mq[0].d;
        end else if (gp) begin
          e.we = (pipe_waddr != 5'd0); e.a = pipe_waddr; e.d = pipe_wd;
        end
        e.b1 = busy_m[rs1_addr];
        e.b2 = busy_m[rs2_addr];
        expq.push_back(e);
        if (rst) begin
          mq.delete();
          head_wait = 0;
          foreach (busy_m[i]) busy_m[i] = 0;
        end else begin
          push = mdu_valid && e.ready;
          if (gm) begin
            busy_m[mq[0].a] = 0;
            void'(mq.pop_front());
          end
          if (issue_valid && issue_rd != 5'd0) busy_m[issue_rd] = 1;
          busy_m[0] = 0;
          if (push) mq.push_back('{a: mdu_waddr, d: mdu_wd});
          if (gm || !hv) head_wait = 0;
          else if (head_wait < MAX_WAIT) head_wait++;
        end
      end
    end
  end

  // Monitor: pops one expectation per cycle and compares against the DUT away from the edge
  initial begin
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        exp_t e;
        e = expq.pop_front();
        chk("rf_we", {31'd0, rf_we}, {31'd0, e.we});
        chk("pipe_stall", {31'd0, pipe_stall}, {31'd0, e.stall});
        chk("mdu_ready", {31'd0, mdu_ready}, {31'd0, e.ready});
        chk("rs1_busy", {31'd0, rs1_busy}, {31'd0, e.b1});
        chk("rs2_busy", {31'd0, rs2_busy}, {31'd0, e.b2});
        if (e.we) begin
          chk("rf_waddr", {27'd0, rf_waddr}, {27'd0, e.a});
          chk("rf_wd", rf_wd, e.d);
        end
      end
    end
  end

  task automatic idle();
    rst = 0; pipe_we = 0; pipe_waddr = 0; pipe_wd = 0;
    mdu_valid = 0; mdu_waddr = 0; mdu_wd = 0;
    issue_valid = 0; issue_rd = 0; rs1_addr = 0; rs2_addr = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic pipe(input logic [4:0] a, input logic [31:0] d);
    pipe_we = 1; pipe_waddr = a; pipe_wd = d;
  endtask

  task automatic mdu(input logic [4:0] a, input logic [31:0] d);
    mdu_valid = 1; mdu_waddr = a; mdu_wd = d;
  endtask

  task automatic issue(input logic [4:0] rd);
    issue_valid = 1; issue_rd = rd;
  endtask

  // Stimulus: directed scenarios followed by randomized traffic
  initial begin
    bit accepted;
    idle();
    rst = 1;
    @(posedge clk);
    #1;
    idle();
    model_on = 1;

    // Reset state, then idle
    @(negedge clk);
    chk("reset rf_we", {31'd0, rf_we}, 32'd0);
    chk("reset mdu_ready", {31'd0, mdu_ready}, 32'd1);
    tick(); tick();

    // Issue to x5, MDU result one cycle later, written the following cycle
    issue(5'd5); rs1_addr = 5'd5; tick();
    mdu(5'd5, 32'hDEADBEEF); rs1_addr = 5'd5;
    @(negedge clk); chk("x5 busy before write", {31'd0, rs1_busy}, 32'd1);
    tick();
    rs1_addr = 5'd5;
    @(negedge clk);
    chk("x5 rf_we", {31'd0, rf_we}, 32'd1);
    chk("x5 rf_waddr", {27'd0, rf_waddr}, 32'd5);
    chk("x5 rf_wd", rf_wd, 32'hDEADBEEF);
    tick();
    rs1_addr = 5'd5;
    @(negedge clk); chk("x5 busy after write", {31'd0, rs1_busy}, 32'd0);
    tick();

    // Buffered MDU result under continuous pipeline writes ages out after MAX_WAIT
    pipe(5'd10, 32'h1111_0000); mdu(5'd6, 32'h6666_6666); tick();
    for (int k = 0; k < MAX_WAIT; k++) begin
      pipe(5'd10, 32'h1111_0000 + k);
      @(negedge clk); chk("aging pipe granted", {31'd0, pipe_stall}, 32'd0);
      tick();
    end
    pipe(5'd10, 32'h1111_00AA);
    @(negedge clk);
    chk("forced stall", {31'd0, pipe_stall}, 32'd1);
    chk("forced waddr", {27'd0, rf_waddr}, 32'd6);
    tick();
    pipe(5'd10, 32'h1111_00AA);
    @(negedge clk);
    chk("held pipe completes", {31'd0, pipe_stall}, 32'd0);
    chk("held pipe waddr", {27'd0, rf_waddr}, 32'd10);
    tick();

    // Two back-to-back MDU results fill the buffer; a third waits for a pop
    pipe(5'd11, 32'h1); mdu(5'd12, 32'hA); tick();
    pipe(5'd11, 32'h2); mdu(5'd13, 32'hB); tick();
    accepted = 0;
    for (int k = 0; k < 20 && !accepted; k++) begin
      pipe(5'd11, 32'h3 + k); mdu(5'd14, 32'hC);
      @(negedge clk);
      if (k == 0) chk("full after two pushes", {31'd0, mdu_ready}, 32'd0);
      accepted = mdu_ready;
      tick();
    end
    if (!accepted) begin
      tests++; fails++;
      $display("FAIL third push timeout: got not accepted expected accepted");
    end
    for (int k = 0; k < 4; k++) tick();

    // Result to x0 consumes the slot without writing; issue to x0 never sets busy
    mdu(5'd0, 32'h0BAD_0BAD); issue(5'd0); tick();
    rs1_addr = 5'd0;
    @(negedge clk);
    chk("x0 rf_we", {31'd0, rf_we}, 32'd0);
    chk("x0 busy", {31'd0, rs1_busy}, 32'd0);
    tick();
    @(negedge clk); chk("x0 popped", {31'd0, mdu_ready}, 32'd1);
    tick();

    // Re-issue to x7 in the same cycle its earlier result retires: busy must stay set
    issue(5'd7); tick();
    mdu(5'd7, 32'h7777_0001); tick();
    issue(5'd7); rs1_addr = 5'd7; tick();
    rs1_addr = 5'd7; mdu(5'd7, 32'h7777_0002);
    @(negedge clk); chk("x7 set wins", {31'd0, rs1_busy}, 32'd1);
    tick(); tick();
    rs1_addr = 5'd7;
    @(negedge clk); chk("x7 cleared", {31'd0, rs1_busy}, 32'd0);
    tick();

    // Reset with results in flight discards them and clears the scoreboard
    pipe(5'd20, 32'h20); mdu(5'd8, 32'h8); issue(5'd9); tick();
    pipe(5'd20, 32'h21); mdu(5'd9, 32'h9); tick();
    rst = 1; tick();
    rs1_addr = 5'd9; rs2_addr = 5'd8;
    @(negedge clk);
    chk("post-reset ready", {31'd0, mdu_ready}, 32'd1);
    chk("post-reset busy", {31'd0, rs1_busy}, 32'd0);
    chk("post-reset rf_we", {31'd0, rf_we}, 32'd0);
    tick();

    // Randomized traffic; pipeline writes avoid registers with pending MDU results
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 1) == 1) begin
        logic [4:0] a;
        a = 5'($urandom_range(0, 31));
        for (int t = 0; t < 8 && busy_m[a]; t++) a = 5'($urandom_range(0, 31));
        if (busy_m[a]) a = 5'd0;
        pipe(a, $urandom);
      end
      if ($urandom_range(0, 1) == 1) mdu(5'($urandom_range(0, 31)), $urandom);
      if ($urandom_range(0, 3) == 0) issue(5'($urandom_range(0, 31)));
      rs1_addr = 5'($urandom_range(0, 31));
      rs2_addr = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 99) == 0) rst = 1;
      tick();
    end

    tick(); tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
